aes128_wb_ctrl: RTL and testbench
=================================

// Module: aes128_wb_ctrl
// PURPOSE
//  Wishbone-slave sequencer for the aes128 pipelined encryption core in user_project_wrapper.
//  - Holds the 128-bit key and plaintext registers that drive aes128.key and aes128.state.
//  - Launches one encryption and counts the core's fixed latency.
//  - Captures aes128.out into a result register and reports BUSY/DONE to the management SoC.
// PARAMETERS
//  BASE_ADDR    32'h3000_0000  Wishbone base; block decodes when wbs_adr_i[31:8]==BASE_ADDR[31:8]
//  AES_LATENCY  21             cycles from stable key/state to valid aes128.out (range 1..255)
// PORTS
//  wb_clk_i    in   1    single clock, also drives aes128.clk
//  wb_rst_i    in   1    synchronous active-high reset
//  wbs_cyc_i   in   1    Wishbone cycle
//  wbs_stb_i   in   1    Wishbone strobe
//  wbs_we_i    in   1    1=write, 0=read
//  wbs_sel_i   in   4    byte enables for writes
//  wbs_adr_i   in   32   byte address; word offset = wbs_adr_i[5:2]
//  wbs_dat_i   in   32   write data
//  wbs_dat_o   out  32   read data
//  wbs_ack_o   out  1    transfer acknowledge
//  aes_key     out  128  to aes128.key
//  aes_state   out  128  to aes128.state (plaintext)
//  aes_out     in   128  from aes128.out (ciphertext)
//  irq         out  1    to user_irq[0]; see CONFIGURATION
// BEHAVIOUR
//  Register map (word offset); multi-word fields are big-endian, so offset 0 holds bits [127:96]:
//  - 0-3 KEY (rw)
//  - 4-7 STATE (rw)
//  - 8 CTRL (wo): bit0 START, bit1 DONE_CLR; both self-clearing; reads return 0
//  - 9 STATUS (ro): bit0 BUSY, bit1 DONE
//  - 12-15 RESULT (ro)
//  - Unmapped offsets: read 0, writes dropped.
//  Bus handshake:
//  - Decoded access: wbs_cyc_i & wbs_stb_i & address match & !wbs_ack_o.
//  - wbs_ack_o rises the cycle after a decoded access and is high for exactly 1 cycle.
//  - Every access therefore takes 2 cycles. A strobe held high is acked once per 2 cycles.
//  - wbs_dat_o is registered alongside ack and is 0 whenever ack is low.
//  - Writes honour wbs_sel_i per byte.
//  FSM and counter:
//  - FSM states IDLE, RUN, CAPT. The counter is 8 bits.
//  - IDLE: a START write moves to RUN, loads cnt=AES_LATENCY-1, and sets BUSY=1, DONE=0.
//  - RUN: decrement cnt each cycle; at cnt==0 go to CAPT.
//  - CAPT (1 cycle): RESULT<=aes_out, BUSY<=0, DONE<=1, then IDLE.
//  - START-to-DONE is AES_LATENCY+1 cycles, counted from the cycle START is accepted.
//  - aes_key/aes_state are continuous copies of KEY/STATE.
//  Boundary conditions:
//  - KEY/STATE writes while BUSY are dropped but still acked, so core inputs stay stable.
//  - START while BUSY is ignored and does not restart the counter.
//  - START with DONE_CLR in the same write: START wins (DONE=0, BUSY=1).
//  - DONE_CLR alone clears DONE. DONE_CLR in the CAPT cycle loses; DONE ends up set.
//  - RESULT holds its last value until the next CAPT. RESULT reads while BUSY return the old value.
//  - Reset, including mid-RUN: IDLE, cnt=0, KEY/STATE/RESULT=0, BUSY=DONE=0, ack=0, dat_o=0, irq=0.
//  - No in-flight result survives reset.
// CONFIGURATION
//  AES_CTRL_IRQ_EN defined:
//  - irq is a registered level equal to DONE: high from the cycle after CAPT until DONE_CLR or START.
//  - STATUS bit2 reads 1.
//  AES_CTRL_IRQ_EN undefined:
//  - irq is tied to 0 and STATUS bit2 reads 0.
//  - Software polls STATUS.DONE.
// TESTING
//  Use the real aes128 core with default AES_LATENCY=21.
//  1. FIPS-197 C.1: KEY=000102030405060708090a0b0c0d0e0f, STATE=00112233445566778899aabbccddeeff, START
//     -> RESULT=69c4e0d86a7b0430d8cdb78070b4c55a; DONE rises exactly 22 cycles after the START ack cycle.
//  2. Write KEY word0=0xFFFFFFFF with sel=4'b0101 -> read-back 0x00FF00FF. Read offset 10 -> 0.
//     Each access acks in 1 cycle and ack stays low the following cycle.
//  3. During RUN: write KEY word0=0xDEADBEEF and issue a second START
//     -> KEY unchanged, aes_key stable, DONE still at cycle 22, RESULT still matches the scenario 1 vector.
//  4. Assert wb_rst_i for 1 cycle at RUN cnt=10
//     -> all registers 0, BUSY=0, and no DONE appears in the following 30 cycles.
//  5. With AES_CTRL_IRQ_EN: irq rises the cycle after CAPT, falls the cycle after a DONE_CLR write.
//     Without the macro: irq stays 0 throughout.
//  6. Same write sets START and DONE_CLR while DONE=1 -> DONE=0 and BUSY=1 in the next cycle.

Source files
------------

// File: rtl/aes128_wb_ctrl.sv
// aes128_wb_ctrl
//   Wishbone slave that sequences one aes128 encryption at a time.
//   It holds the 128-bit KEY and STATE (plaintext) registers that feed the core.
//   A START launches the core and the block counts the core's fixed latency.
//   The core output is then captured into RESULT and the block reports BUSY/DONE.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_cyc_i, wbs_stb_i        Wishbone cycle / strobe
//   wbs_we_i, wbs_sel_i         write enable, byte enables
//   wbs_adr_i, wbs_dat_i        byte address (word offset = adr[5:2]), write data
//   wbs_dat_o, wbs_ack_o        registered read data, one-cycle acknowledge
//   aes_key, aes_state          continuous copies of KEY / STATE to the core
//   aes_out                     ciphertext from the core
//   irq                         DONE level interrupt (optional feature)
//
// Register map (word offsets, big-endian multi-word fields: offset 0 = bits [127:96])
//   0-3 KEY rw, 4-7 STATE rw, 8 CTRL wo (bit0 START, bit1 DONE_CLR),
//   9 STATUS ro (bit0 BUSY, bit1 DONE, bit2 irq feature present), 12-15 RESULT ro
//
// Build option
//   AES_CTRL_IRQ_EN : when defined, irq is a registered copy of DONE and
//                     STATUS bit2 reads 1; otherwise irq is 0 and bit2 reads 0.

module aes128_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          AES_LATENCY = 21
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic [31:0]  wbs_dat_o,
  output logic         wbs_ack_o,
  output logic [127:0] aes_key,
  output logic [127:0] aes_state,
  input  logic [127:0] aes_out,
  output logic         irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   pt_q, pt_d;
  logic [127:0]   res_q, res_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ack_q, ack_d;
  logic           irq_q, irq_d;
  logic [31:0]    dat_q, dat_d;

  logic           acc, wr, rd;
  logic [3:0]     off;
  logic [1:0]     widx;
  logic           start, done_clr;
  logic           irq_present;
  logic [31:0]    rdata;
  logic           unused_adr_bits;

  localparam logic [7:0] CNT_LOAD = 8'(AES_LATENCY - 1);

  assign unused_adr_bits = ^{wbs_adr_i[7:6], wbs_adr_i[1:0]};

`ifdef AES_CTRL_IRQ_EN
  assign irq_present = 1'b1;
`else
  assign irq_present = 1'b0;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // The !ack term makes a held strobe decode only every other cycle.
  assign acc  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~ack_q;
  assign wr   = acc & wbs_we_i;
  assign rd   = acc & ~wbs_we_i;
  assign off  = wbs_adr_i[5:2];
  // Big-endian word order: offset 0 addresses bits [127:96], i.e. slice 3.
  assign widx = ~off[1:0];

  assign start    = wr & (off == 4'd8) & wbs_sel_i[0] & wbs_dat_i[0];
  assign done_clr = wr & (off == 4'd8) & wbs_sel_i[0] & wbs_dat_i[1];

  always_comb begin
    rdata = 32'd0;
    case (off[3:2])
      2'd0: rdata = key_q[{widx, 5'b0} +: 32];
      2'd1: rdata = pt_q[{widx, 5'b0} +: 32];
      2'd2: if (off[1:0] == 2'd1) rdata = {29'd0, irq_present, done_q, busy_q};
      2'd3: rdata = res_q[{widx, 5'b0} +: 32];
      default: rdata = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    pt_d    = pt_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = done_q;
    ack_d   = acc;
    dat_d   = rd ? rdata : 32'd0;

    // Core inputs are frozen while an encryption is in flight.
    if (wr && !busy_q) begin
      if (off[3:2] == 2'd0)
        key_d[{widx, 5'b0} +: 32] = merge_bytes(key_q[{widx, 5'b0} +: 32], wbs_dat_i, wbs_sel_i);
      else if (off[3:2] == 2'd1)
        pt_d[{widx, 5'b0} +: 32] = merge_bytes(pt_q[{widx, 5'b0} +: 32], wbs_dat_i, wbs_sel_i);
    end

    case (state_q)
      IDLE: begin
        // START takes priority over a DONE_CLR in the same write.
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end else if (done_clr) begin
          done_d = 1'b0;
        end
      end
      RUN: begin
        if (done_clr) done_d = 1'b0;
        if (cnt_q == 8'd0) state_d = CAPT;
        else               cnt_d   = cnt_q - 8'd1;
      end
      CAPT: begin
        // A DONE_CLR landing here is overridden by the capture.
        res_d   = aes_out;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef AES_CTRL_IRQ_EN
    irq_d = done_d;
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      key_q   <= 128'd0;
      pt_q    <= 128'd0;
      res_q   <= 128'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      irq_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      irq_q   <= irq_d;
      dat_q   <= dat_d;
    end
  end

  assign wbs_dat_o = dat_q;
  assign wbs_ack_o = ack_q;
  assign aes_key   = key_q;
  assign aes_state = pt_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_aes128_wb_ctrl.sv
// Bench for aes128_wb_ctrl. The aes128 core is represented by a 21-stage
// pipeline whose stage function returns the FIPS-197 C.1 ciphertext for the
// C.1 key/plaintext and key^plaintext for anything else.
module tb_aes128_wb_ctrl;

  localparam logic [31:0]  BASE = 32'h3000_0000;
  localparam int           LAT  = 21;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_CTRL_IRQ_EN
  localparam logic [31:0] SI = 32'd4;
  localparam logic        IRQ_EXP = 1'b1;
`else
  localparam logic [31:0] SI = 32'd0;
  localparam logic        IRQ_EXP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, dat_i, dat_o;
  logic         ack;
  logic [127:0] aes_key, aes_state, aes_out;
  logic         irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_rd;
    logic [31:0] exp;
    string       nm;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic prev_ack = 1'b0;

  always #5 clk = ~clk;

  aes128_wb_ctrl #(.BASE_ADDR(BASE), .AES_LATENCY(LAT)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o),
    .wbs_ack_o(ack),
    .aes_key  (aes_key),
    .aes_state(aes_state),
    .aes_out  (aes_out),
    .irq      (irq)
  );

  // Core latency model
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] p);
    return (k == FK && p == FP) ? FC : (k ^ p);
  endfunction

  logic [127:0] pipe [LAT];
  initial for (int i = 0; i < LAT; i++) pipe[i] = 128'd0;
  always @(posedge clk) begin
    pipe[0] <= core_f(aes_key, aes_state);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign aes_out = pipe[LAT-1];

  // Monitor: pops the scoreboard on every ack, checks ack framing and idle data
  always @(negedge clk) begin
    if (ack) begin
      checks++;
      if (prev_ack) begin
        errors++;
        $display("FAIL ack_back_to_back: ack high two cycles in a row, required one");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack=1 with no access outstanding");
      end else begin
        e = sb.pop_front();
        if (e.is_rd) begin
          checks++;
          if (dat_o !== e.exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", e.nm, dat_o, e.exp);
          end
        end
      end
    end else if (!rst) begin
      checks++;
      if (dat_o !== 32'd0) begin
        errors++;
        $display("FAIL dat_o_idle: got %08h expected 00000000 while ack low", dat_o);
      end
    end
`ifndef AES_CTRL_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_tied: got %b expected 0", irq);
    end
`endif
    prev_ack = ack;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %032h expected %032h", nm, act, exp);
    end
  endtask

  // One access: drive at a negedge, decode on the next posedge,
  // ack must be high one cycle later and low the cycle after.
  task automatic xfer(input logic w, input logic [3:0] s, input logic [3:0] o,
                      input logic [31:0] d, input logic [31:0] x, input string nm);
    sb.push_back('{is_rd: ~w, exp: x, nm: nm});
    cyc = 1'b1; stb = 1'b1; we = w; sel = s;
    adr = BASE | {26'd0, o, 2'b00};
    dat_i = d;
    @(negedge clk);
    chk({nm, "_ack"}, {127'd0, ack}, 128'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = 32'd0;
    @(negedge clk);
    chk({nm, "_ack_low"}, {127'd0, ack}, 128'd0);
  endtask

  task automatic wr(input logic [3:0] o, input logic [31:0] d, input logic [3:0] s = 4'hF);
    xfer(1'b1, s, o, d, 32'd0, "wr");
  endtask

  task automatic rd(input logic [3:0] o, input logic [31:0] x, input string nm);
    xfer(1'b0, 4'hF, o, 32'd0, x, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'd0; dat_i = 32'd0;
    idle(3);
    // Reset state
    chk("rst_ack", {127'd0, ack}, 128'd0);
    chk("rst_dat", {96'd0, dat_o}, 128'd0);
    chk("rst_key", aes_key, 128'd0);
    chk("rst_state", aes_state, 128'd0);
    chk("rst_irq", {127'd0, irq}, 128'd0);
    rst = 1'b0;
    idle(1);
    rd(9, SI, "rst_status");
    rd(12, 32'd0, "rst_result0");

    // Byte enables, unmapped and write-only reads
    wr(0, 32'hFFFF_FFFF, 4'b0101);
    rd(0, 32'h00FF_00FF, "sel_readback");
    rd(10, 32'd0, "unmapped_rd");
    wr(10, 32'h1234_5678);
    rd(10, 32'd0, "unmapped_after_wr");
    rd(8, 32'd0, "ctrl_rd");

    // FIPS-197 C.1
    wr(0, FK[127:96]); wr(1, FK[95:64]); wr(2, FK[63:32]); wr(3, FK[31:0]);
    wr(4, FP[127:96]); wr(5, FP[95:64]); wr(6, FP[63:32]); wr(7, FP[31:0]);
    rd(0, FK[127:96], "key_w0");
    rd(7, FP[31:0], "state_w3");
    chk("aes_key_fips", aes_key, FK);
    chk("aes_state_fips", aes_state, FP);
    wr(8, 32'd1);                       // START decoded at E0, now at N1
    rd(12, 32'd0, "result_old_busy");   // now N3
    idle(18);                           // N21
    chk("irq_before_done", {127'd0, irq}, 128'd0);
    rd(9, 32'd1 | SI, "status_e22");    // decoded E22: still BUSY
    chk("irq_after_capt", {127'd0, irq}, {127'd0, IRQ_EXP});
    rd(9, 32'd2 | SI, "status_e24");
    rd(12, FC[127:96], "res_w0"); rd(13, FC[95:64], "res_w1");
    rd(14, FC[63:32], "res_w2");  rd(15, FC[31:0], "res_w3");

    // Writes and a second START during RUN are ignored
    wr(8, 32'd1);                       // E0, now N1
    wr(0, 32'hDEAD_BEEF);               // E2
    wr(8, 32'd1);                       // E4, now N5
    chk("aes_key_stable", aes_key, FK);
    rd(12, FC[127:96], "result_hold_busy"); // now N7
    idle(15);                           // N22
    rd(9, 32'd2 | SI, "status_e23");    // decoded E23: DONE already set
    rd(0, FK[127:96], "key_unchanged");
    rd(12, FC[127:96], "res2_w0"); rd(15, FC[31:0], "res2_w3");

    // START together with DONE_CLR while DONE=1
    wr(8, 32'd3);
    chk("irq_start_clr", {127'd0, irq}, 128'd0);
    rd(9, 32'd1 | SI, "start_wins");
    idle(25);
    rd(9, 32'd2 | SI, "done_again");
    chk("irq_level", {127'd0, irq}, {127'd0, IRQ_EXP});

    // DONE_CLR alone
    wr(8, 32'd2);
    chk("irq_cleared", {127'd0, irq}, 128'd0);
    rd(9, SI, "done_cleared");

    // Reset in mid-RUN at cnt=10
    wr(8, 32'd1);                       // E0, now N1
    idle(9);                            // N10
    rst = 1'b1;
    idle(1);                            // reset sampled at E11
    rst = 1'b0;
    chk("mid_rst_ack", {127'd0, ack}, 128'd0);
    chk("mid_rst_dat", {96'd0, dat_o}, 128'd0);
    chk("mid_rst_key", aes_key, 128'd0);
    chk("mid_rst_state", aes_state, 128'd0);
    chk("mid_rst_irq", {127'd0, irq}, 128'd0);
    for (int i = 0; i < 15; i++) rd(9, SI, "no_done_after_rst");
    rd(12, 32'd0, "rst_res_w0"); rd(15, 32'd0, "rst_res_w3");
    rd(0, 32'd0, "rst_key_w0");  rd(4, 32'd0, "rst_state_w0");

    // Fresh run after reset: RESULT keeps old value until capture
    wr(3, 32'h1111_1111);
    wr(8, 32'd1);
    rd(15, 32'd0, "res_old_until_capt");
    idle(25);
    rd(9, 32'd2 | SI, "done_post_rst");
    rd(15, 32'h1111_1111, "res_new_w3");
    rd(12, 32'd0, "res_new_w0");

    idle(3);
    chk("scoreboard_empty", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
